// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: coordinate/score widths, playfield
// bounds (also used by the apple generator) and apple tracker state types.
package snake_pkg;

  localparam int COORD_W = 11;
  localparam int SCORE_W = 8;
  localparam int RETRY_W = 6;

  localparam int MIN_X = 16;
  localparam int MAX_X = 1392;
  localparam int MIN_Y = 16;
  localparam int MAX_Y = 848;

  typedef enum logic {
    SPAWN  = 1'b0,
    ACTIVE = 1'b1
  } apple_state_t;

  // Why a candidate was refused; the first failing rule wins.
  typedef enum logic [1:0] {
    CR_NONE = 2'd0,
    CR_OOB  = 2'd1,
    CR_WALL = 2'd2,
    CR_HEAD = 2'd3
  } cand_reason_t;

endpackage

// File: rtl/apple_cand_check.sv
// Combinational legality check of a generator candidate against the playfield
// bounds, the wall and the snake head, with a debug reason code.
module apple_cand_check
  import snake_pkg::*;
#(
  parameter int COORD_W = snake_pkg::COORD_W,
  parameter int MIN_X   = snake_pkg::MIN_X,
  parameter int MAX_X   = snake_pkg::MAX_X,
  parameter int MIN_Y   = snake_pkg::MIN_Y,
  parameter int MAX_Y   = snake_pkg::MAX_Y
) (
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  input  logic [COORD_W-1:0] wallpos_x,
  input  logic [COORD_W-1:0] wallpos_y,
  input  logic [COORD_W-1:0] snakehead_x,
  input  logic [COORD_W-1:0] snakehead_y,
  output logic               ok,
  output cand_reason_t       reason
);

  logic [1:0] in_bounds;
  logic       on_wall;
  logic       on_head;

  // Axis 0 is x, axis 1 is y; each gets its own inclusive window.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [COORD_W-1:0] LO = COORD_W'((gi == 0) ? MIN_X : MIN_Y);
    localparam logic [COORD_W-1:0] HI = COORD_W'((gi == 0) ? MAX_X : MAX_Y);
    logic [COORD_W-1:0] coord;
    assign coord         = (gi == 0) ? cand_x : cand_y;
    assign in_bounds[gi] = (coord >= LO) && (coord <= HI);
  end

  assign on_wall = (cand_x == wallpos_x)   && (cand_y == wallpos_y);
  assign on_head = (cand_x == snakehead_x) && (cand_y == snakehead_y);

  always_comb begin
    reason = CR_NONE;
    if (in_bounds != 2'b11) begin
      reason = CR_OOB;
    end else if (on_wall) begin
      reason = CR_WALL;
    end else if (on_head) begin
      reason = CR_HEAD;
    end
  end

  assign ok = (in_bounds == 2'b11) && !on_wall && !on_head;

endmodule

// File: rtl/apple_tracker.sv
// Apple consumer: samples generator candidates while an apple is needed, holds
// the accepted apple, detects the snake eating it on move steps and keeps score.
module apple_tracker
  import snake_pkg::*;
#(
  parameter int COORD_W = snake_pkg::COORD_W,
  parameter int SCORE_W = snake_pkg::SCORE_W,
  parameter int RETRY_W = snake_pkg::RETRY_W,
  parameter int MIN_X   = snake_pkg::MIN_X,
  parameter int MAX_X   = snake_pkg::MAX_X,
  parameter int MIN_Y   = snake_pkg::MIN_Y,
  parameter int MAX_Y   = snake_pkg::MAX_Y
) (
  input  logic               clk,
  input  logic               btnrst_n,
  input  logic               game_en,
  input  logic               move_tick,
  input  logic [COORD_W-1:0] snakehead_x,
  input  logic [COORD_W-1:0] snakehead_y,
  input  logic [COORD_W-1:0] wallpos_x,
  input  logic [COORD_W-1:0] wallpos_y,
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  output logic [COORD_W-1:0] apple_x,
  output logic [COORD_W-1:0] apple_y,
  output logic               apple_valid,
  output logic               eaten,
  output logic [SCORE_W-1:0] score,
  output logic [RETRY_W-1:0] reject_cnt
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

  apple_state_t       state_reg,       state_next;
  logic [COORD_W-1:0] apple_x_reg,     apple_x_next;
  logic [COORD_W-1:0] apple_y_reg,     apple_y_next;
  logic               apple_valid_reg, apple_valid_next;
  logic               eaten_reg,       eaten_next;
  logic [SCORE_W-1:0] score_reg,       score_next;
  logic [RETRY_W-1:0] reject_cnt_reg,  reject_cnt_next;

  logic         cand_ok;
  cand_reason_t cand_reason;
  logic         cand_accept;
  logic         head_on_apple;

  apple_cand_check #(
    .COORD_W (COORD_W),
    .MIN_X   (MIN_X),
    .MAX_X   (MAX_X),
    .MIN_Y   (MIN_Y),
    .MAX_Y   (MAX_Y)
  ) u_cand_check (
    .cand_x      (cand_x),
    .cand_y      (cand_y),
    .wallpos_x   (wallpos_x),
    .wallpos_y   (wallpos_y),
    .snakehead_x (snakehead_x),
    .snakehead_y (snakehead_y),
    .ok          (cand_ok),
    .reason      (cand_reason)
  );

  // Accept only when the checker's verdict and its reason code agree.
  assign cand_accept   = cand_ok && (cand_reason == CR_NONE);
  assign head_on_apple = (snakehead_x == apple_x_reg) && (snakehead_y == apple_y_reg);

  always_ff @(posedge clk or negedge btnrst_n) begin
    if (!btnrst_n) begin
      state_reg       <= SPAWN;
      apple_x_reg     <= '0;
      apple_y_reg     <= '0;
      apple_valid_reg <= 1'b0;
      eaten_reg       <= 1'b0;
      score_reg       <= '0;
      reject_cnt_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      apple_x_reg     <= apple_x_next;
      apple_y_reg     <= apple_y_next;
      apple_valid_reg <= apple_valid_next;
      eaten_reg       <= eaten_next;
      score_reg       <= score_next;
      reject_cnt_reg  <= reject_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    apple_x_next     = apple_x_reg;
    apple_y_next     = apple_y_reg;
    apple_valid_next = apple_valid_reg;
    eaten_next       = 1'b0;
    score_next       = score_reg;
    reject_cnt_next  = reject_cnt_reg;

    if (game_en) begin
      unique case (state_reg)
        SPAWN: begin
          if (cand_accept) begin
            apple_x_next     = cand_x;
            apple_y_next     = cand_y;
            apple_valid_next = 1'b1;
            reject_cnt_next  = '0;
            state_next       = ACTIVE;
          end else if (reject_cnt_reg != RETRY_MAX) begin
            reject_cnt_next = reject_cnt_reg + 1'b1;
          end
        end
        ACTIVE: begin
          // Collisions are only resolved on a move step; apple coords are kept.
          if (move_tick && head_on_apple) begin
            eaten_next       = 1'b1;
            apple_valid_next = 1'b0;
            state_next       = SPAWN;
            if (score_reg != SCORE_MAX) begin
              score_next = score_reg + 1'b1;
            end
          end
        end
        default: state_next = SPAWN;
      endcase
    end
  end

  assign apple_x     = apple_x_reg;
  assign apple_y     = apple_y_reg;
  assign apple_valid = apple_valid_reg;
  assign eaten       = eaten_reg;
  assign score       = score_reg;
  assign reject_cnt  = reject_cnt_reg;

endmodule

// File: doc/apple_tracker.md
Name: apple_tracker

Overview:
Consumer side of the apple position generator. Samples the generator's free-running candidate coordinates only when an apple is needed. Rejects candidates that are out of bounds or that land on the wall or the snake head. Holds the accepted apple stable for the renderer, detects the snake eating it on each move step, and keeps the score. Sits between the apple generator, the snake movement logic and the VGA draw logic.

Parameters:
COORD_W, 11, width of all x/y coordinates
SCORE_W, 8, width of score counter (saturating)
RETRY_W, 6, width of consecutive-reject counter (saturating)
MIN_X, 16, lowest legal apple x (inclusive)
MAX_X, 1392, highest legal apple x (inclusive)
MIN_Y, 16, lowest legal apple y (inclusive)
MAX_Y, 848, highest legal apple y (inclusive)

Ports:
clk  in  1  system clock
btnrst_n  in  1  asynchronous active-low reset
game_en  in  1  high while the game runs; low freezes the block
move_tick  in  1  one-cycle pulse per snake step
snakehead_x  in  COORD_W  current head x
snakehead_y  in  COORD_W  current head y
wallpos_x  in  COORD_W  wall x
wallpos_y  in  COORD_W  wall y
cand_x  in  COORD_W  generator candidate x (changes every cycle)
cand_y  in  COORD_W  generator candidate y
apple_x  out  COORD_W  held apple x
apple_y  out  COORD_W  held apple y
apple_valid  out  1  apple on screen
eaten  out  1  one-cycle pulse when apple eaten
score  out  SCORE_W  apples eaten, saturating
reject_cnt  out  RETRY_W  consecutive rejected candidates in current spawn

Behaviour:
- Reset (btnrst_n=0, async): state=SPAWN; apple_x=apple_y=0; apple_valid=0; eaten=0; score=0; reject_cnt=0. Takes effect immediately, mid-operation included.
- States: SPAWN, ACTIVE. All outputs are registered.
- Candidate ok (combinational) when all of these hold:
  - MIN_X<=cand_x<=MAX_X and MIN_Y<=cand_y<=MAX_Y
  - not (cand_x==wallpos_x and cand_y==wallpos_y)
  - not (cand_x==snakehead_x and cand_y==snakehead_y)
- SPAWN, game_en=1, ok=1: at next edge, apple_x/y<=cand, apple_valid<=1, reject_cnt<=0, state<=ACTIVE. Latency is one clock from sample to apple_valid.
- SPAWN, game_en=1, ok=0: reject_cnt increments, saturating at 2^RETRY_W-1; stay in SPAWN. The candidate changes every cycle, so the block retries on the next one.
- SPAWN ignores move_tick; eaten stays 0.
- ACTIVE, game_en=1, move_tick=1, head==apple (both coordinates): at next edge, eaten<=1 for exactly one cycle, score<=score+1 (holds at 2^SCORE_W-1), apple_valid<=0, state<=SPAWN. apple_x/y hold their last value.
- ACTIVE without move_tick: no collision check, even if head==apple. Apple holds.
- game_en=0: state, apple, score and reject_cnt frozen; eaten=0; no candidate accepted.
- Earliest respawn: apple_valid returns on the cycle after eaten at the soonest (SPAWN entered, then accept).
- Wall or head moving onto a held apple does not invalidate it; only the eat rule removes an apple.

Decomposition:
- Shared package snake_pkg holds:
  - COORD_W, SCORE_W
  - MIN_X/MAX_X/MIN_Y/MAX_Y bounds, shared with the generator
  - apple_state_t enum {SPAWN, ACTIVE}
- One sub-module, apple_cand_check: purely combinational. Inputs are cand, wall, head and the bounds; outputs are ok and a reason code (oob/wall/head) for debug.

Test Plan:
- Reset release, game_en=1, cand=(48,16), wall=(400,400), head=(200,208) -> next edge apple=(48,16), apple_valid=1, reject_cnt=0.
- SPAWN, cand=(400,400)=wall for 3 cycles, then (80,80) -> reject_cnt 1,2,3, then apple=(80,80), reject_cnt=0.
- ACTIVE apple=(80,80), head=(80,80), move_tick pulse -> eaten high exactly one cycle, score 0->1, apple_valid 0, then re-accept the next legal cand.
- Head==apple with move_tick=0 for 10 cycles -> no eaten, score unchanged; cand=(1424,16) in SPAWN -> rejected as out of bounds.
- score=255 then eat -> score stays 255, eaten still pulses; game_en=0 with head==apple and move_tick -> no eaten.
- Assert btnrst_n low asynchronously while eaten=1 -> all outputs zero immediately, state SPAWN.
